// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main control FSM.
// Imported by ctrl_out_decode and multicycle_ctrl.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_EXEC,
      S_R_WB,
      S_BRANCH,
      S_ADDI_EX,
      S_ADDI_WB,
      S_JUMP
   } ctrl_state_t;

   // Opcodes as 6-bit values; users zero-extend them to their opcode width.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUB_REG   = 2'b00;
   localparam logic [1:0] ALUB_ONE   = 2'b01;
   localparam logic [1:0] ALUB_IMM   = 2'b10;
   localparam logic [1:0] ALUB_SHIFT = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       branch_ne;
      logic [1:0] pc_source;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_sigs_t;

   // States that hold a memory access open until mem_ready.
   function automatic logic is_mem_wait(input ctrl_state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational control-output map from FSM state, opcode and mem_ready.
// Memory-completion outputs are gated by mem_ready in the stall states.
module ctrl_out_decode
   import ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  ctrl_state_t       state_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic              mem_ready_i,
   output ctrl_sigs_t        sigs_o
);

   localparam logic [OP_W-1:0] C_R    = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] C_LW   = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] C_SW   = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] C_BEQ  = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] C_BNE  = OP_W'(OP_BNE);
   localparam logic [OP_W-1:0] C_ADDI = OP_W'(OP_ADDI);
   localparam logic [OP_W-1:0] C_J    = OP_W'(OP_J);

   logic op_known;

   assign op_known = (op_i == C_R) || (op_i == C_LW) || (op_i == C_SW) ||
                     (op_i == C_BEQ) || (op_i == C_BNE) || (op_i == C_ADDI) ||
                     (op_i == C_J);

   always_comb begin
      sigs_o = '0;
      case (state_i)
         S_FETCH: begin
            sigs_o.mem_read  = 1'b1;
            sigs_o.alu_src_b = ALUB_ONE;
            sigs_o.alu_op    = ALUOP_ADD;
            sigs_o.pc_source = PCSRC_ALU;
            sigs_o.ir_write  = mem_ready_i;
            sigs_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            sigs_o.alu_src_b  = ALUB_SHIFT;
            sigs_o.alu_op     = ALUOP_ADD;
            sigs_o.illegal_op = ~op_known;
         end
         S_MEM_ADDR, S_ADDI_EX: begin
            sigs_o.alu_src_a = 1'b1;
            sigs_o.alu_src_b = ALUB_IMM;
            sigs_o.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            sigs_o.mem_read = 1'b1;
            sigs_o.iord     = 1'b1;
         end
         S_MEM_WB: begin
            sigs_o.reg_write  = 1'b1;
            sigs_o.mem_to_reg = 1'b1;
            sigs_o.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            sigs_o.mem_write  = 1'b1;
            sigs_o.iord       = 1'b1;
            sigs_o.instr_done = mem_ready_i;
         end
         S_EXEC: begin
            sigs_o.alu_src_a = 1'b1;
            sigs_o.alu_src_b = ALUB_REG;
            sigs_o.alu_op    = ALUOP_FUNCT;
         end
         S_R_WB: begin
            sigs_o.reg_write  = 1'b1;
            sigs_o.reg_dst    = 1'b1;
            sigs_o.instr_done = 1'b1;
         end
         S_BRANCH: begin
            sigs_o.alu_src_a     = 1'b1;
            sigs_o.alu_src_b     = ALUB_REG;
            sigs_o.alu_op        = ALUOP_SUB;
            sigs_o.pc_write_cond = 1'b1;
            sigs_o.pc_source     = PCSRC_ALUOUT;
            sigs_o.branch_ne     = (op_i == C_BNE);
            sigs_o.instr_done    = 1'b1;
         end
         S_ADDI_WB: begin
            sigs_o.reg_write  = 1'b1;
            sigs_o.instr_done = 1'b1;
         end
         S_JUMP: begin
            sigs_o.pc_write   = 1'b1;
            sigs_o.pc_source  = PCSRC_JUMP;
            sigs_o.instr_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle main control FSM: state register, sequencing, memory stall timeout.
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OP_W        = 6,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [OP_W-1:0]   op,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              pc_write_cond,
   output logic              branch_ne,
   output logic [1:0]        pc_source,
   output logic              iord,
   output logic              mem_read,
   output logic              mem_write,
   output logic              ir_write,
   output logic              mem_to_reg,
   output logic              reg_dst,
   output logic              reg_write,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [1:0]        alu_op,
   output logic              instr_done,
   output logic              illegal_op,
   output logic              mem_err,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  instr_cnt,
   output ctrl_state_t       state_dbg
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [OP_W-1:0] C_R    = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] C_LW   = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] C_SW   = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] C_BEQ  = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] C_BNE  = OP_W'(OP_BNE);
   localparam logic [OP_W-1:0] C_ADDI = OP_W'(OP_ADDI);
   localparam logic [OP_W-1:0] C_J    = OP_W'(OP_J);

   ctrl_state_t       state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              stalling;
   logic              timeout;
   ctrl_sigs_t        sigs;

   assign stalling = is_mem_wait(state_q) && !mem_ready;
   assign timeout  = stalling && (MEM_TIMEOUT != 0) &&
                     (wait_q == WAIT_W'(MEM_TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Counter is zero on entry to every stall state, including FETCH re-entry after an abort.
   always_comb begin
      wait_d = '0;
      if (stalling && !timeout) wait_d = wait_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     state_d = S_FETCH;
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (op == C_R)                      state_d = S_EXEC;
            else if (op == C_LW || op == C_SW)  state_d = S_MEM_ADDR;
            else if (op == C_BEQ || op == C_BNE) state_d = S_BRANCH;
            else if (op == C_ADDI)              state_d = S_ADDI_EX;
            else if (op == C_J)                 state_d = S_JUMP;
            else                                state_d = S_FETCH;
         end
         S_MEM_ADDR: state_d = (op == C_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (mem_ready)    state_d = S_MEM_WB;
            else if (timeout) state_d = S_FETCH;
         end
         S_MEM_WR: if (mem_ready || timeout) state_d = S_FETCH;
         S_EXEC:     state_d = S_R_WB;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_ADDI_WB, S_JUMP: state_d = S_FETCH;
         default:    state_d = S_IDLE;
      endcase
   end

   ctrl_out_decode #(.OP_W(OP_W)) u_decode (
      .state_i     (state_q),
      .op_i        (op),
      .mem_ready_i (mem_ready),
      .sigs_o      (sigs)
   );

   assign pc_write      = sigs.pc_write;
   assign pc_write_cond = sigs.pc_write_cond;
   assign branch_ne     = sigs.branch_ne;
   assign pc_source     = sigs.pc_source;
   assign iord          = sigs.iord;
   assign mem_read      = sigs.mem_read;
   assign mem_write     = sigs.mem_write;
   assign ir_write      = sigs.ir_write;
   assign mem_to_reg    = sigs.mem_to_reg;
   assign reg_dst       = sigs.reg_dst;
   assign reg_write     = sigs.reg_write;
   assign alu_src_a     = sigs.alu_src_a;
   assign alu_src_b     = sigs.alu_src_b;
   assign alu_op        = sigs.alu_op;
   assign instr_done    = sigs.instr_done;
   assign illegal_op    = sigs.illegal_op;
   assign mem_err       = timeout;
   assign state_dbg     = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] instr_q, instr_d;

   assign cycle_d = cycle_q + CNT_W'(1);
   assign instr_d = instr_q + CNT_W'(sigs.instr_done);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycle_cnt = cycle_q;
   assign instr_cnt = instr_q;
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule
